// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit memory controller: funct3 codes,
// byte-lane selects and the controller state encoding.
package lsu_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   localparam logic [1:0] LANE_B0 = 2'd0;
   localparam logic [1:0] LANE_B1 = 2'd1;
   localparam logic [1:0] LANE_B2 = 2'd2;
   localparam logic [1:0] LANE_B3 = 2'd3;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_MERGE,
      ST_WRITE,
      ST_RESP
   } lsu_state_e;

   // Stores only support the three unsigned-agnostic sizes; loads add BU/HU.
   function automatic logic f3_legal(input logic [2:0] f3, input logic store);
      logic ok;
      ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
      if (!store) ok = ok || (f3 == F3_BU) || (f3 == F3_HU);
      return ok;
   endfunction

   function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] lane);
      return ((f3[1:0] == 2'b01) && lane[0]) || ((f3[1:0] == 2'b10) && (lane != 2'b00));
   endfunction

endpackage

// File: rtl/lsu_byte_lane.sv
// Combinational lane logic: extracts and extends a load lane, or merges store
// data into the addressed lane of a word while preserving the other lanes.
module lsu_byte_lane
   import lsu_pkg::*;
#(
   parameter int N = 32
) (
   input  logic [N-1:0] word_i,
   input  logic [N-1:0] wdata_i,
   input  logic [1:0]   lane_i,
   input  logic [2:0]   funct3_i,
   input  logic         merge_i,
   output logic [N-1:0] result_o
);

   logic [4:0]   shamt;
   logic [7:0]   lane_byte;
   logic [15:0]  lane_half;
   logic [N-1:0] ext;
   logic [N-1:0] mask;
   logic [N-1:0] merged;

   always_comb begin
      case (lane_i)
         LANE_B0: shamt = 5'd0;
         LANE_B1: shamt = 5'd8;
         LANE_B2: shamt = 5'd16;
         LANE_B3: shamt = 5'd24;
         default: shamt = 5'd0;
      endcase

      lane_byte = word_i[shamt +: 8];
      lane_half = word_i[shamt +: 16];

      case (funct3_i)
         F3_B:    ext = {{(N-8){lane_byte[7]}}, lane_byte};
         F3_H:    ext = {{(N-16){lane_half[15]}}, lane_half};
         F3_BU:   ext = {{(N-8){1'b0}}, lane_byte};
         F3_HU:   ext = {{(N-16){1'b0}}, lane_half};
         default: ext = word_i;
      endcase

      case (funct3_i[1:0])
         2'b00:   mask = {{(N-8){1'b0}}, 8'hFF} << shamt;
         2'b01:   mask = {{(N-16){1'b0}}, 16'hFFFF} << shamt;
         default: mask = '1;
      endcase

      merged   = (word_i & ~mask) | ((wdata_i << shamt) & mask);
      result_o = merge_i ? merged : ext;
   end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store sequencer between a core request port and a single-ported,
// combinationally read word memory. Sub-word stores use read-modify-write.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | ready for a request; mem_a follows req_addr
// ST_LOAD  | read addressed word, extract/extend lane into resp_rdata
// ST_MERGE | read addressed word, splice SB/SH data into its lane
// ST_WRITE | single write pulse of full or merged word
// ST_RESP  | one-cycle completion (and error) pulse
module lsu_mem_ctrl
   import lsu_pkg::*;
#(
   parameter int N        = 32,
   parameter int MEM_SIZE = 1024
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         req_valid,
   output logic         req_ready,
   input  logic [2:0]   req_funct3,
   input  logic         req_store,
   input  logic [N-1:0] req_addr,
   input  logic [N-1:0] req_wdata,
   output logic         resp_valid,
   output logic [N-1:0] resp_rdata,
   output logic         resp_err,
   output logic         mem_we,
   output logic [N-1:0] mem_a,
   output logic [N-1:0] mem_wd,
   input  logic [N-1:0] mem_rd
);

   lsu_state_e   state_q, state_d;
   logic [N-1:0] addr_q, addr_d;
   logic [2:0]   funct3_q, funct3_d;
   logic         store_q, store_d;
   logic [N-1:0] wdata_q, wdata_d;
   logic         err_q, err_d;
   logic [N-1:0] rdata_q, rdata_d;
   logic [N-1:0] merged_q, merged_d;

   logic [N-1:0] req_idx;
   logic         req_bad;
   logic [N-1:0] load_lane;
   logic [N-1:0] merge_lane;

   assign req_idx = req_addr >> 2;
   assign req_bad = !f3_legal(req_funct3, req_store)
                 || misaligned(req_funct3, req_addr[1:0])
                 || (req_idx >= N'(MEM_SIZE));

   lsu_byte_lane #(.N(N)) u_load_lane (
      .word_i   (mem_rd),
      .wdata_i  ('0),
      .lane_i   (addr_q[1:0]),
      .funct3_i (funct3_q),
      .merge_i  (1'b0),
      .result_o (load_lane)
   );

   lsu_byte_lane #(.N(N)) u_merge_lane (
      .word_i   (mem_rd),
      .wdata_i  (wdata_q),
      .lane_i   (addr_q[1:0]),
      .funct3_i (funct3_q),
      .merge_i  (1'b1),
      .result_o (merge_lane)
   );

   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      funct3_d = funct3_q;
      store_d  = store_q;
      wdata_d  = wdata_q;
      err_d    = err_q;
      rdata_d  = rdata_q;
      merged_d = merged_q;

      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               addr_d   = req_addr;
               funct3_d = req_funct3;
               store_d  = req_store;
               wdata_d  = req_wdata;
               err_d    = req_bad;
               rdata_d  = '0;
               if (req_bad)                 state_d = ST_RESP;
               else if (!req_store)         state_d = ST_LOAD;
               else if (req_funct3 == F3_W) state_d = ST_WRITE;
               else                         state_d = ST_MERGE;
            end
         end
         ST_LOAD: begin
            rdata_d = load_lane;
            state_d = ST_RESP;
         end
         ST_MERGE: begin
            merged_d = merge_lane;
            state_d  = ST_WRITE;
         end
         ST_WRITE: state_d = ST_RESP;
         ST_RESP:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= ST_IDLE;
         addr_q   <= '0;
         funct3_q <= '0;
         store_q  <= 1'b0;
         wdata_q  <= '0;
         err_q    <= 1'b0;
         rdata_q  <= '0;
         merged_q <= '0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         funct3_q <= funct3_d;
         store_q  <= store_d;
         wdata_q  <= wdata_d;
         err_q    <= err_d;
         rdata_q  <= rdata_d;
         merged_q <= merged_d;
      end
   end

   // Outputs decode straight from state so an async reset clears them at once.
   always_comb begin
      req_ready  = (state_q == ST_IDLE);
      resp_valid = (state_q == ST_RESP);
      resp_err   = (state_q == ST_RESP) && err_q;
      resp_rdata = rdata_q;
      mem_we     = (state_q == ST_WRITE);
      mem_a      = (state_q == ST_IDLE) ? req_idx : {2'b00, addr_q[N-1:2]};
      mem_wd     = '0;
      if (state_q == ST_WRITE)
         mem_wd = (store_q && funct3_q == F3_W) ? wdata_q : merged_q;
   end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl with a behavioural word memory.
module tb_lsu_mem_ctrl;

   logic        clk;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic [2:0]  req_funct3;
   logic        req_store;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic        mem_we;
   logic [31:0] mem_a;
   logic [31:0] mem_wd;
   logic [31:0] mem_rd;

   logic [31:0] mem [0:1023];
   logic        pk_en;
   logic [9:0]  pk_a;
   logic [31:0] pk_d;

   int n_vec  = 0;
   int n_miss = 0;

   lsu_mem_ctrl #(.N(32), .MEM_SIZE(1024)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_funct3 (req_funct3),
      .req_store  (req_store),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_rdata (resp_rdata),
      .resp_err   (resp_err),
      .mem_we     (mem_we),
      .mem_a      (mem_a),
      .mem_wd     (mem_wd),
      .mem_rd     (mem_rd)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign mem_rd = (mem_a < 32'd1024) ? mem[mem_a[9:0]] : 32'h0;

   always @(posedge clk) begin
      if (pk_en)
         mem[pk_a] <= pk_d;
      else if (mem_we && mem_a < 32'd1024)
         mem[mem_a[9:0]] <= mem_wd;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h, want %h", tag, obs, exp);
      end
   endtask

   task automatic poke(input logic [9:0] a, input logic [31:0] d);
      @(negedge clk);
      pk_en = 1'b1; pk_a = a; pk_d = d;
      @(posedge clk);
      #1 pk_en = 1'b0;
   endtask

   task automatic run_req(input logic st, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, output int lat, output logic [31:0] rd,
                          output logic er, output int wes, output logic [31:0] wa,
                          output logic [31:0] wdv);
      lat = 0; rd = '0; er = 1'b0; wes = 0; wa = '0; wdv = '0;
      @(negedge clk);
      req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
      @(posedge clk);
      #1 req_valid = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         if (mem_we) begin
            wes++; wa = mem_a; wdv = mem_wd;
         end
         if (resp_valid) begin
            lat = k; rd = resp_rdata; er = resp_err;
            break;
         end
      end
   endtask

   task automatic do_req(input string tag, input logic st, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd, input int elat,
                         input logic [31:0] erd, input logic eer, input int ewes);
      int lat, wes;
      logic [31:0] rd, wa, wdv;
      logic er;
      run_req(st, f3, a, wd, lat, rd, er, wes, wa, wdv);
      chk({tag, ".lat"},   32'(lat), 32'(elat));
      chk({tag, ".rdata"}, rd, erd);
      chk({tag, ".err"},   {31'b0, er}, {31'b0, eer});
      chk({tag, ".we"},    32'(wes), 32'(ewes));
   endtask

   task automatic do_sub_store(input string tag, input logic [2:0] f3, input logic [31:0] a,
                               input logic [31:0] wd, input logic [31:0] eidx,
                               input logic [31:0] eword);
      int lat, wes;
      logic [31:0] rd, wa, wdv;
      logic er;
      run_req(1'b1, f3, a, wd, lat, rd, er, wes, wa, wdv);
      chk({tag, ".lat"},   32'(lat), 32'd3);
      chk({tag, ".we"},    32'(wes), 32'd1);
      chk({tag, ".mem_a"}, wa, eidx);
      chk({tag, ".mem_wd"}, wdv, eword);
      chk({tag, ".err"},   {31'b0, er}, 32'd0);
      chk({tag, ".mem"},   mem[eidx[9:0]], eword);
   endtask

   initial begin
      int we_seen, rv_seen, n_resp, n_acc, bad_acc;
      logic [31:0] exp_b2b [3];

      rst = 1'b0; req_valid = 1'b0; req_funct3 = '0; req_store = 1'b0;
      req_addr = 32'h0; req_wdata = '0; pk_en = 1'b0; pk_a = '0; pk_d = '0;

      repeat (2) @(negedge clk);
      chk("rst.ready", {31'b0, req_ready}, 32'd1);
      chk("rst.resp_valid", {31'b0, resp_valid}, 32'd0);
      chk("rst.resp_err", {31'b0, resp_err}, 32'd0);
      chk("rst.rdata", resp_rdata, 32'd0);
      chk("rst.mem_we", {31'b0, mem_we}, 32'd0);
      chk("rst.mem_wd", mem_wd, 32'd0);
      rst = 1'b1;

      poke(10'd2, 32'h0);
      poke(10'd3, 32'h11223344);
      poke(10'd4, 32'hCAFEF00D);
      poke(10'd5, 32'h8899AABB);
      poke(10'd6, 32'h55667788);
      poke(10'd7, 32'hA0A0A0A0);
      poke(10'd8, 32'hB1B1B1B1);
      poke(10'd9, 32'hC2C2C2C2);

      do_req("lb16",  1'b0, 3'b000, 32'h16, 32'h0, 2, 32'hFFFFFF99, 1'b0, 0);
      do_req("lhu14", 1'b0, 3'b101, 32'h14, 32'h0, 2, 32'h0000AABB, 1'b0, 0);
      do_req("lh15",  1'b0, 3'b001, 32'h15, 32'h0, 1, 32'h00000000, 1'b1, 0);
      do_req("lbu17", 1'b0, 3'b100, 32'h17, 32'h0, 2, 32'h00000088, 1'b0, 0);
      do_req("lh16",  1'b0, 3'b001, 32'h16, 32'h0, 2, 32'hFFFF8899, 1'b0, 0);
      do_req("lw14",  1'b0, 3'b010, 32'h14, 32'h0, 2, 32'h8899AABB, 1'b0, 0);
      do_req("lw_mis", 1'b0, 3'b010, 32'h16, 32'h0, 1, 32'h0, 1'b1, 0);
      do_req("ld_f3",  1'b0, 3'b011, 32'h14, 32'h0, 1, 32'h0, 1'b1, 0);
      do_req("st_f3",  1'b1, 3'b100, 32'h14, 32'h5A, 1, 32'h0, 1'b1, 0);

      do_sub_store("sb0d", 3'b000, 32'h0D, 32'h000000EE, 32'd3, 32'h1122EE44);
      do_sub_store("sh12", 3'b001, 32'h12, 32'h00001234, 32'd4, 32'h1234F00D);

      do_req("sw_oor", 1'b1, 3'b010, 32'h1000, 32'h12345678, 1, 32'h0, 1'b1, 0);
      do_req("lw_last", 1'b0, 3'b010, 32'hFFC, 32'h0, 2, 32'hxxxxxxxx, 1'b0, 0);
      do_req("sw08", 1'b1, 3'b010, 32'h08, 32'hDEADBEEF, 2, 32'h0, 1'b0, 1);
      chk("sw08.mem", mem[2], 32'hDEADBEEF);

      // Reset while the SH is in its read-modify-write merge cycle.
      do_req("lw_pre", 1'b0, 3'b010, 32'h14, 32'h0, 2, 32'h8899AABB, 1'b0, 0);
      @(negedge clk);
      req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'b001;
      req_addr = 32'h18; req_wdata = 32'h0000BEEF;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rstm.ready", {31'b0, req_ready}, 32'd1);
      chk("rstm.resp_valid", {31'b0, resp_valid}, 32'd0);
      chk("rstm.mem_we", {31'b0, mem_we}, 32'd0);
      chk("rstm.mem_wd", mem_wd, 32'd0);
      chk("rstm.rdata", resp_rdata, 32'd0);
      we_seen = 0; rv_seen = 0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         if (mem_we) we_seen++;
         if (resp_valid) rv_seen++;
      end
      rst = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         if (mem_we) we_seen++;
         if (resp_valid) rv_seen++;
      end
      chk("rstm.we_cnt", 32'(we_seen), 32'd0);
      chk("rstm.rv_cnt", 32'(rv_seen), 32'd0);
      chk("rstm.mem6", mem[6], 32'h55667788);

      // Three LWs with req_valid held high throughout.
      exp_b2b[0] = 32'hA0A0A0A0;
      exp_b2b[1] = 32'hB1B1B1B1;
      exp_b2b[2] = 32'hC2C2C2C2;
      n_resp = 0; n_acc = 0; bad_acc = 0; we_seen = 0;
      @(negedge clk);
      req_valid = 1'b1; req_store = 1'b0; req_funct3 = 3'b010; req_addr = 32'h1C;
      for (int cyc = 0; cyc < 30 && n_resp < 3; cyc++) begin
         if (cyc != 0) @(negedge clk);
         if (mem_we) we_seen++;
         if (resp_valid) begin
            if (req_ready) bad_acc++;
            chk($sformatf("b2b.rdata%0d", n_resp), resp_rdata, exp_b2b[n_resp]);
            n_resp++;
         end else if (req_ready && req_valid) begin
            n_acc++;
            @(posedge clk);
            #1;
            if (n_acc < 3) req_addr = req_addr + 32'd4;
            else req_valid = 1'b0;
         end
      end
      req_valid = 1'b0;
      chk("b2b.resp_cnt", 32'(n_resp), 32'd3);
      chk("b2b.acc_cnt", 32'(n_acc), 32'd3);
      chk("b2b.resp_accept", 32'(bad_acc), 32'd0);
      chk("b2b.we_cnt", 32'(we_seen), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
